// File: rtl/systolic_skew_feeder_if.sv
// Operand-feeder bus: pass control, aligned input beat stream and skewed fabric-edge output.
// Lane i of each vector bus occupies bits [i*WIDTH +: WIDTH].
interface systolic_skew_feeder_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic                     start;
    logic [CNT_W-1:0]         k_len;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*WIDTH-1:0]   in_data;
    logic [LANES*WIDTH-1:0]   out_data;
    logic [LANES-1:0]         out_lane_valid;
    logic                     busy;
    logic                     done;

    modport master (
        output start, k_len, in_valid, in_data,
        input  in_ready, out_data, out_lane_valid, busy, done
    );

    modport slave (
        input  start, k_len, in_valid, in_data,
        output in_ready, out_data, out_lane_valid, busy, done
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Diagonal skew feeder: lane i of each accepted vector reaches the fabric edge i+1 cycles later,
// then zeros are flushed until the last lane's final element has been presented.

module skew_lane #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_vld,
    input  logic [WIDTH-1:0] ld_data,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data
);
    logic [DEPTH-1:0]            vld_pipe_q, vld_pipe_d;
    logic [DEPTH-1:0][WIDTH-1:0] dat_pipe_q, dat_pipe_d;

    // Non-accepted cycles inject a zero element so bubbles stay MAC-neutral.
    always_comb begin
        vld_pipe_d    = '0;
        dat_pipe_d    = '0;
        vld_pipe_d[0] = ld_vld;
        dat_pipe_d[0] = ld_vld ? ld_data : '0;
        for (int k = 1; k < DEPTH; k++) begin
            vld_pipe_d[k] = vld_pipe_q[k-1];
            dat_pipe_d[k] = dat_pipe_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe_q <= '0;
            dat_pipe_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            dat_pipe_q <= dat_pipe_d;
        end
    end

    assign out_vld  = vld_pipe_q[DEPTH-1];
    assign out_data = dat_pipe_q[DEPTH-1];
endmodule

module systolic_skew_feeder #(
    parameter int LANES = 4,
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    systolic_skew_feeder_if.slave  bus
);
    localparam int FC_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic              accept;

    logic [LANES-1:0][WIDTH-1:0] lane_dat;
    logic [LANES-1:0]            lane_vld;

    // remaining is never zero in FEED; the guard keeps the counter from wrapping regardless.
    assign accept = (state_q == S_FEED) && bus.in_valid && (remaining_q != '0);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.k_len != '0) begin
                        state_d     = S_FEED;
                        remaining_d = bus.k_len;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FEED: begin
                if (accept) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        if (LANES == 1) begin
                            state_d = S_DONE;
                        end else begin
                            state_d     = S_FLUSH;
                            flush_cnt_d = FC_W'(LANES - 1);
                        end
                    end
                end
            end
            S_FLUSH: begin
                // Counter covers LANES cycles so the deepest lane drains its last element.
                if (flush_cnt_q == '0) state_d = S_DONE;
                else                   flush_cnt_d = flush_cnt_q - FC_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        skew_lane #(
            .DEPTH (i + 1),
            .WIDTH (WIDTH)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .ld_vld   (accept),
            .ld_data  (bus.in_data[i*WIDTH +: WIDTH]),
            .out_vld  (lane_vld[i]),
            .out_data (lane_dat[i])
        );
    end

    assign bus.out_data       = lane_dat;
    assign bus.out_lane_valid = lane_vld;
    assign bus.in_ready       = (state_q == S_FEED);
    assign bus.busy           = (state_q == S_FEED) || (state_q == S_FLUSH);
    assign bus.done           = (state_q == S_DONE);
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: per-cycle vector table plus a reset-abort sequence.
module tb_systolic_skew_feeder;
    localparam int LANES = 4;
    localparam int WIDTH = 16;
    localparam int CNT_W = 16;

    localparam logic [2:0] C_I = 3'b000;  // {in_ready, busy, done}
    localparam logic [2:0] C_F = 3'b110;
    localparam logic [2:0] C_L = 3'b010;
    localparam logic [2:0] C_D = 3'b001;

    localparam logic [63:0] VA  = 64'h0A03_0A02_0A01_0A00;
    localparam logic [63:0] VB  = 64'h0B03_0B02_0B01_0B00;
    localparam logic [63:0] V1  = 64'h0004_0003_0002_0001;

    typedef struct {
        logic        s;
        logic [15:0] k;
        logic        v;
        logic [63:0] d;
        logic [2:0]  ctl;
        logic [3:0]  olv;
        logic [63:0] dout;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    systolic_skew_feeder_if #(.LANES(LANES), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    systolic_skew_feeder #(.LANES(LANES), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   failures = 0;
    vec_t tbl[$];

    function automatic void add(input logic s, input logic [15:0] k, input logic v,
                                input logic [63:0] d, input logic [2:0] ctl,
                                input logic [3:0] olv, input logic [63:0] dout);
        vec_t r;
        r = '{s, k, v, d, ctl, olv, dout};
        tbl.push_back(r);
    endfunction

    function automatic logic [70:0] obs();
        return {bus.in_ready, bus.busy, bus.done, bus.out_lane_valid, bus.out_data};
    endfunction

    task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [15:0] k, input logic v, input logic [63:0] d);
        bus.start    = s;
        bus.k_len    = k;
        bus.in_valid = v;
        bus.in_data  = d;
    endtask

    initial begin
        int cnt;
        drive(0, 0, 0, '0);

        // test 1: single vector
        add(1, 1, 0, '0, C_I, 4'b0000, '0);
        add(0, 0, 1, V1, C_F, 4'b0000, '0);
        add(0, 0, 0, '0, C_L, 4'b0001, 64'h0000_0000_0000_0001);
        add(0, 0, 0, '0, C_L, 4'b0010, 64'h0000_0000_0002_0000);
        add(0, 0, 0, '0, C_L, 4'b0100, 64'h0000_0003_0000_0000);
        add(0, 0, 0, '0, C_L, 4'b1000, 64'h0004_0000_0000_0000);
        add(0, 0, 0, '0, C_D, 4'b0000, '0);
        // test 2: streaming, started right after done; in_valid during FLUSH not consumed
        add(1, 3, 0, '0, C_I, 4'b0000, '0);
        add(0, 0, 1, 64'h0011_0011_0011_0011, C_F, 4'b0000, '0);
        add(0, 0, 1, 64'h0022_0022_0022_0022, C_F, 4'b0001, 64'h0000_0000_0000_0011);
        add(0, 0, 1, 64'h0033_0033_0033_0033, C_F, 4'b0011, 64'h0000_0000_0011_0022);
        add(0, 0, 1, 64'h0044_0044_0044_0044, C_L, 4'b0111, 64'h0000_0011_0022_0033);
        add(0, 0, 0, '0, C_L, 4'b1110, 64'h0011_0022_0033_0000);
        add(0, 0, 0, '0, C_L, 4'b1100, 64'h0022_0033_0000_0000);
        add(0, 0, 0, '0, C_L, 4'b1000, 64'h0033_0000_0000_0000);
        add(1, 2, 0, '0, C_D, 4'b0000, '0);
        add(0, 0, 0, '0, C_I, 4'b0000, '0);
        // test 3: bubble between two vectors
        add(1, 2, 0, '0, C_I, 4'b0000, '0);
        add(0, 0, 1, VA, C_F, 4'b0000, '0);
        add(0, 0, 0, '0, C_F, 4'b0001, 64'h0000_0000_0000_0A00);
        add(0, 0, 1, VB, C_F, 4'b0010, 64'h0000_0000_0A01_0000);
        add(0, 0, 0, '0, C_L, 4'b0101, 64'h0000_0A02_0000_0B00);
        add(0, 0, 0, '0, C_L, 4'b1010, 64'h0A03_0000_0B01_0000);
        add(0, 0, 0, '0, C_L, 4'b0100, 64'h0000_0B02_0000_0000);
        add(0, 0, 0, '0, C_L, 4'b1000, 64'h0B03_0000_0000_0000);
        add(0, 0, 0, '0, C_D, 4'b0000, '0);
        add(0, 0, 1, VA, C_I, 4'b0000, '0);
        // test 4: zero length, in_valid held high throughout
        add(1, 0, 1, VA, C_I, 4'b0000, '0);
        add(0, 0, 1, VA, C_D, 4'b0000, '0);
        add(0, 0, 1, VA, C_I, 4'b0000, '0);
        // test 6: start with k_len=9 during FEED and FLUSH is ignored
        add(1, 2, 0, '0, C_I, 4'b0000, '0);
        add(1, 9, 1, VA, C_F, 4'b0000, '0);
        add(1, 9, 1, VB, C_F, 4'b0001, 64'h0000_0000_0000_0A00);
        add(1, 9, 0, '0, C_L, 4'b0011, 64'h0000_0000_0A01_0B00);
        add(0, 0, 0, '0, C_L, 4'b0110, 64'h0000_0A02_0B01_0000);
        add(0, 0, 0, '0, C_L, 4'b1100, 64'h0A03_0B02_0000_0000);
        add(0, 0, 0, '0, C_L, 4'b1000, 64'h0B03_0000_0000_0000);
        add(0, 0, 0, '0, C_D, 4'b0000, '0);
        add(0, 0, 0, '0, C_I, 4'b0000, '0);
        add(0, 0, 0, '0, C_I, 4'b0000, '0);

        #12;
        check("reset_state", obs(), '0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            if (i > 0) @(negedge clk);
            drive(tbl[i].s, tbl[i].k, tbl[i].v, tbl[i].d);
            check($sformatf("row%0d", i), obs(), {tbl[i].ctl, tbl[i].olv, tbl[i].dout});
        end

        // test 5: reset abort during FLUSH, then a normal pass
        @(negedge clk);
        drive(1, 1, 0, '0);
        @(negedge clk);
        drive(0, 0, 1, V1);
        check("abort_feed", obs(), {C_F, 4'b0000, 64'h0});
        @(negedge clk);
        drive(0, 0, 0, '0);
        check("abort_flush0", obs(), {C_L, 4'b0001, 64'h0000_0000_0000_0001});
        @(negedge clk);
        check("abort_flush1", obs(), {C_L, 4'b0010, 64'h0000_0000_0002_0000});
        #2;
        reset = 1'b0;
        #1;
        check("abort_immediate", obs(), '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("abort_quiet%0d", c), obs(), '0);
        end

        drive(1, 1, 0, '0);
        @(negedge clk);
        drive(0, 0, 1, V1);
        check("restart_feed", obs(), {C_F, 4'b0000, 64'h0});
        @(negedge clk);
        drive(0, 0, 0, '0);
        cnt = 1;
        check("restart_lane0", obs(), {C_L, 4'b0001, 64'h0000_0000_0000_0001});
        while (!bus.done && cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (cnt == 4) check("restart_lane3", obs(), {C_L, 4'b1000, 64'h0004_0000_0000_0000});
        end
        check("restart_done_latency", 71'(cnt), 71'(5));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
